// File: rtl/fp_div_pkg.sv
// Shared constants and stage encoding for the pipelined FP divider control path.
package fp_div_pkg;

    localparam int unsigned FP_W = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StS1   = 2'd1,
        StS2   = 2'd2,
        StS3   = 2'd3
    } stage_e;

    // Collapse the one-hot sequencer strobes back into a stage code.
    function automatic stage_e strobe_stage(input logic s1, input logic s2, input logic s3);
        stage_e st;
        st = StIdle;
        if (s1) begin
            st = StS1;
        end else if (s2) begin
            st = StS2;
        end else if (s3) begin
            st = StS3;
        end
        return st;
    endfunction

    function automatic logic multi_strobe(input logic s1, input logic s2, input logic s3);
        return (s1 & s2) | (s1 & s3) | (s2 & s3);
    endfunction

endpackage

// File: rtl/fp_div_out_fifo.sv
// Result FIFO for the FP divider: first-word fall-through read, push/pop in the same cycle
// keeps count unchanged.
module fp_div_out_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned FP_W  = 32
) (
    input  logic                     clk_in,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic [FP_W-1:0]          push_data_i,
    input  logic                     pop_i,
    output logic                     valid_o,
    output logic [FP_W-1:0]          data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [FP_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic [CntW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage is cleared on reset so the empty head reads as zero.
    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    assign valid_o = (count_q != '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fp_div_result_ctrl.sv
// Issue/collect controller for the 3-stage FP divider; optional strobe-protocol checker
// enabled by defining FP_DIV_SEQ_CHECK_EN.
module fp_div_result_ctrl
    import fp_div_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned FP_W  = fp_div_pkg::FP_W
) (
    input  logic            clk_in,
    input  logic            reset_n,
    input  logic            op_valid,
    output logic            op_ready,
    output logic            fsm_enable,
    input  logic            enable_stage1,
    input  logic            enable_stage2,
    input  logic            enable_stage3,
    input  logic [FP_W-1:0] result_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FP_W-1:0] out_data,
    output logic            seq_err
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;
    localparam logic [CntW:0] DepthLim = DEPTH[CntW:0];

    logic            busy_q, busy_d;
    logic [1:0]      in_flight_q, in_flight_d;
    logic            cap_pend_q, cap_pend_d;
    logic [CntW-1:0] count;
    logic [CntW:0]   credit_used;
    logic            accept;
    logic            pop;

    // in_flight counts ops accepted but not yet written: an op accepted during the S3
    // cycle overlaps the previous op's capture, so up to two can be outstanding.
    assign credit_used = {1'b0, count} + {{(CntW - 1){1'b0}}, in_flight_q};
    assign op_ready    = ~busy_q & (credit_used < DepthLim);
    assign fsm_enable  = busy_q;
    assign accept      = op_valid & op_ready;
    assign pop         = out_valid & out_ready;

    always_comb begin
        busy_d      = busy_q;
        in_flight_d = in_flight_q;
        cap_pend_d  = enable_stage3;
        if (accept) begin
            busy_d = 1'b1;
        end else if (enable_stage2) begin
            busy_d = 1'b0;
        end
        case ({accept, cap_pend_q && (in_flight_q != 2'd0)})
            2'b10:   in_flight_d = in_flight_q + 2'd1;
            2'b01:   in_flight_d = in_flight_q - 2'd1;
            default: in_flight_d = in_flight_q;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            busy_q      <= 1'b0;
            in_flight_q <= 2'd0;
            cap_pend_q  <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            in_flight_q <= in_flight_d;
            cap_pend_q  <= cap_pend_d;
        end
    end

    fp_div_out_fifo #(
        .DEPTH (DEPTH),
        .FP_W  (FP_W)
    ) u_fifo (
        .clk_in      (clk_in),
        .reset_n     (reset_n),
        .push_i      (cap_pend_q),
        .push_data_i (result_in),
        .pop_i       (pop),
        .valid_o     (out_valid),
        .data_o      (out_data),
        .count_o     (count)
    );

`ifdef FP_DIV_SEQ_CHECK_EN
    stage_e prev_stage_q;
    logic   seq_err_q, seq_err_d;
    logic   viol;

    always_comb begin
        viol = multi_strobe(enable_stage1, enable_stage2, enable_stage3)
             | (enable_stage2 & (prev_stage_q != StS1))
             | (enable_stage3 & (prev_stage_q != StS2))
             | ((enable_stage1 | enable_stage2 | enable_stage3) & ~busy_q
                & (in_flight_q == 2'd0));
        seq_err_d = seq_err_q | viol;
    end

    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            prev_stage_q <= StIdle;
            seq_err_q    <= 1'b0;
        end else begin
            prev_stage_q <= strobe_stage(enable_stage1, enable_stage2, enable_stage3);
            seq_err_q    <= seq_err_d;
        end
    end

    assign seq_err = seq_err_q;
`else
    logic unused_stage1;
    assign unused_stage1 = enable_stage1;
    assign seq_err       = 1'b0;
`endif

endmodule

// File: tb/tb_fp_div_result_ctrl.sv
// Bench for fp_div_result_ctrl: directed table, randomized traffic against a timing-level
// model, mid-op reset and strobe-error injection.
module tb_fp_div_result_ctrl;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned W     = 32;
`ifdef FP_DIV_SEQ_CHECK_EN
    localparam logic SEQ_EXP = 1'b1;
`else
    localparam logic SEQ_EXP = 1'b0;
`endif

    logic         clk_in = 1'b0;
    logic         reset_n;
    logic         op_valid, op_ready, fsm_enable;
    logic         enable_stage1, enable_stage2, enable_stage3;
    logic [W-1:0] result_in;
    logic         out_valid, out_ready;
    logic [W-1:0] out_data;
    logic         seq_err;
    logic         inj_s1, inj_s3;
    logic [W-1:0] next_res;

    always #5 clk_in = ~clk_in;

    fp_div_result_ctrl #(
        .DEPTH (DEPTH),
        .FP_W  (W)
    ) dut (
        .clk_in        (clk_in),
        .reset_n       (reset_n),
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .fsm_enable    (fsm_enable),
        .enable_stage1 (enable_stage1),
        .enable_stage2 (enable_stage2),
        .enable_stage3 (enable_stage3),
        .result_in     (result_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .seq_err       (seq_err)
    );

    // Environment: stage sequencer and a datapath returning each op's result after S3.
    fp_div_pkg::stage_e seq_q;
    logic [W-1:0]       dp_q[$];

    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            seq_q <= fp_div_pkg::StIdle;
        end else begin
            case (seq_q)
                fp_div_pkg::StIdle: if (fsm_enable) seq_q <= fp_div_pkg::StS1;
                fp_div_pkg::StS1:   seq_q <= fp_div_pkg::StS2;
                fp_div_pkg::StS2:   seq_q <= fp_div_pkg::StS3;
                default: seq_q <= fsm_enable ? fp_div_pkg::StS1 : fp_div_pkg::StIdle;
            endcase
        end
    end

    assign enable_stage1 = (seq_q == fp_div_pkg::StS1) | inj_s1;
    assign enable_stage2 = (seq_q == fp_div_pkg::StS2);
    assign enable_stage3 = (seq_q == fp_div_pkg::StS3) | inj_s3;

    always @(posedge clk_in) begin
        if (!reset_n) begin
            dp_q.delete();
            result_in <= $urandom;
        end else begin
            if (op_valid && op_ready) dp_q.push_back(next_res);
            if (seq_q == fp_div_pkg::StS3 && dp_q.size() > 0) result_in <= dp_q.pop_front();
            else result_in <= $urandom;
        end
    end

    // Model: an op accepted at edge a keeps the unit busy after edges a..a+2 and its
    // result becomes visible after edge a+5; credits = accepted - popped.
    typedef struct {
        int           avail;
        logic [W-1:0] val;
    } mentry_t;

    mentry_t mq[$];
    int      cyc = 0;
    int      acc_last = -100;
    int      accepted = 0;
    int      popped = 0;
    int      n_vec = 0;
    int      n_err = 0;

    typedef struct {
        logic         ov;
        logic         ordy;
        logic [W-1:0] res;
        logic         e_rdy;
        logic         e_fsm;
        logic         e_ov;
        logic [W-1:0] e_data;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic model_busy();
        return (cyc - acc_last) <= 2;
    endfunction

    function automatic logic model_rdy();
        return !model_busy() && ((accepted - popped) < int'(DEPTH));
    endfunction

    function automatic logic model_ov();
        return (mq.size() > 0) && (mq[0].avail <= cyc);
    endfunction

    task automatic check_model();
        chk("fsm_enable", fsm_enable, model_busy());
        chk("op_ready", op_ready, model_rdy());
        chk("out_valid", out_valid, model_ov());
        if (model_ov()) chk("out_data", out_data, mq[0].val);
        chk("seq_err", seq_err, 1'b0);
    endtask

    task automatic advance(input logic ov, input logic ordy, input logic [W-1:0] res);
        logic acc, pop;
        acc      = ov && model_rdy();
        pop      = model_ov() && ordy;
        op_valid = ov;
        out_ready = ordy;
        next_res = res;
        @(posedge clk_in);
        cyc++;
        if (pop) begin
            mq.delete(0);
            popped++;
        end
        if (acc) begin
            mq.push_back('{avail: cyc + 5, val: res});
            accepted++;
            acc_last = cyc;
        end
        @(negedge clk_in);
    endtask

    task automatic step(input logic ov, input logic ordy, input logic [W-1:0] res);
        check_model();
        advance(ov, ordy, res);
    endtask

    task automatic clear_model();
        mq.delete();
        accepted = 0;
        popped   = 0;
        acc_last = -100;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        op_valid  = 1'b0;
        out_ready = 1'b0;
        inj_s1    = 1'b0;
        inj_s3    = 1'b0;
        repeat (2) begin
            @(posedge clk_in);
            cyc++;
        end
        @(negedge clk_in);
        reset_n = 1'b1;
        clear_model();
    endtask

    initial begin
        next_res = '0;
        // Single op: busy 3 cycles, result visible after the fifth edge, then popped.
        tbl[0] = '{1'b1, 1'b0, 32'h3FC00000, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[1] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0};
        tbl[2] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0};
        tbl[3] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0};
        tbl[4] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0};
        tbl[5] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0};
        tbl[6] = '{1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 1'b1, 32'h3FC00000};
        tbl[7] = '{1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0};

        do_reset();
        chk("reset_seq_err", seq_err, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("tbl%0d_op_ready", i), op_ready, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_fsm_enable", i), fsm_enable, tbl[i].e_fsm);
            chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].e_ov);
            chk($sformatf("tbl%0d_out_data", i), out_data, tbl[i].e_data);
            advance(tbl[i].ov, tbl[i].ordy, tbl[i].res);
        end

        // Back-to-back ops with a free-flowing sink.
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, $urandom);
        // Stalled sink fills the FIFO and must throttle op_ready.
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0, $urandom);
        // Random traffic exercises simultaneous push/pop and credit limits.
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(3) != 0, $urandom_range(1) != 0, $urandom);
        end
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, $urandom);

        // Reset during S2 discards the in-flight op.
        do_reset();
        step(1'b1, 1'b1, 32'hDEAD0001);
        step(1'b0, 1'b1, $urandom);
        step(1'b0, 1'b1, $urandom);
        reset_n = 1'b0;
        @(posedge clk_in);
        cyc++;
        @(negedge clk_in);
        reset_n = 1'b1;
        clear_model();
        chk("rst_mid_fsm_enable", fsm_enable, 1'b0);
        chk("rst_mid_out_valid", out_valid, 1'b0);
        chk("rst_mid_op_ready", op_ready, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, $urandom);

        // Illegal strobe pair while idle.
        inj_s1 = 1'b1;
        inj_s3 = 1'b1;
        @(posedge clk_in);
        cyc++;
        @(negedge clk_in);
        inj_s1 = 1'b0;
        inj_s3 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("seq_err_hold%0d", i), seq_err, SEQ_EXP);
            @(posedge clk_in);
            cyc++;
            @(negedge clk_in);
        end
        do_reset();
        chk("seq_err_after_reset", seq_err, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
